// File: rtl/sd_init_ctrl.sv
// SD card identification/initialisation sequencer driving cmd_driver.
// Optional CMD55+ACMD6 4-bit bus switch enabled by SD_INIT_WIDE_BUS_EN.
module sd_init_ctrl #(
    parameter int          ACMD41_RETRIES = 1000,
    parameter logic [31:0] ACMD41_ARG     = 32'h40FF8000,
    parameter int          GAP_CYCLES     = 8
) (
    input  logic          iclk,
    input  logic          irst,
    input  logic          istart,
    output logic          ocmd_start,
    output logic [5:0]    ocmd_index,
    output logic [31:0]   ocmd_arg,
    input  logic [119:0]  icmd_resp,
    input  logic          icmd_done,
    output logic [15:0]   orca,
    output logic          obusy,
    output logic          odone,
    output logic          oerror,
    output logic [2:0]    oerr_code,
    output logic          obus4
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD0,
        S_CMD8,
        S_CMD55,
        S_ACMD41,
        S_CMD2,
        S_CMD3,
        S_CMD7,
        S_CMD55B,
        S_ACMD6,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int RW = $clog2(ACMD41_RETRIES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [2:0] ERR_CMD8  = 3'd1;
    localparam logic [2:0] ERR_TMO   = 3'd2;
    localparam logic [2:0] ERR_INDEX = 3'd3;

    state_t        state;
    state_t        nxt;
    logic [2:0]    nerr;
    logic          wait_gap;
    logic [RW-1:0] retry_cnt;
    logic [RW-1:0] retry_nx;
    logic [GW-1:0] gap_cnt;
    logic          gap_end;
    logic [5:0]    r_idx;
    logic [31:0]   r_arg;
    logic          unused_resp;

    assign r_idx       = icmd_resp[37:32];
    assign r_arg       = icmd_resp[31:0];
    assign unused_resp = ^{icmd_resp[119:38], icmd_resp[15:12]};
    assign retry_nx    = retry_cnt + 1'b1;
    assign gap_end     = (GAP_CYCLES == 0) ||
                         (gap_cnt == GW'(GAP_CYCLES - 1));

    function automatic logic [5:0] idx_of(state_t s);
        logic [5:0] i;
        case (s)
            S_CMD8:            i = 6'd8;
            S_CMD55, S_CMD55B: i = 6'd55;
            S_ACMD41:          i = 6'd41;
            S_CMD2:            i = 6'd2;
            S_CMD3:            i = 6'd3;
            S_CMD7:            i = 6'd7;
            S_ACMD6:           i = 6'd6;
            default:           i = 6'd0;
        endcase
        return i;
    endfunction

    function automatic logic [31:0] arg_of(state_t s, logic [15:0] rca);
        logic [31:0] a;
        case (s)
            S_CMD8:                    a = 32'h0000_01AA;
            S_CMD55, S_CMD55B, S_CMD7: a = {rca, 16'h0000};
            S_ACMD41:                  a = ACMD41_ARG;
            S_ACMD6:                   a = 32'h0000_0002;
            default:                   a = 32'h0000_0000;
        endcase
        return a;
    endfunction

    // Response check and successor for the command whose done is sampled now
    always_comb begin
        nxt  = state;
        nerr = 3'd0;
        case (state)
            S_CMD0: nxt = S_CMD8;
            S_CMD8: begin
                if (r_idx == 6'd8 && r_arg[11:0] == 12'h1AA) begin
                    nxt = S_CMD55;
                end else begin
                    nxt  = S_ERROR;
                    nerr = ERR_CMD8;
                end
            end
            S_CMD55: begin
                if (r_idx == 6'd55) begin
                    nxt = S_ACMD41;
                end else begin
                    nxt  = S_ERROR;
                    nerr = ERR_INDEX;
                end
            end
            S_ACMD41: begin
                if (r_arg[31]) begin
                    nxt = S_CMD2;
                end else if (retry_nx == RW'(ACMD41_RETRIES)) begin
                    nxt  = S_ERROR;
                    nerr = ERR_TMO;
                end else begin
                    nxt = S_CMD55;
                end
            end
            S_CMD2: nxt = S_CMD3;
            S_CMD3: begin
                if (r_idx != 6'd3) begin
                    nxt  = S_ERROR;
                    nerr = ERR_INDEX;
                end else if (r_arg[31:16] == 16'h0000) begin
                    nxt = S_CMD3;
                end else begin
                    nxt = S_CMD7;
                end
            end
            S_CMD7: begin
                if (r_idx == 6'd7) begin
`ifdef SD_INIT_WIDE_BUS_EN
                    nxt = S_CMD55B;
`else
                    nxt = S_DONE;
`endif
                end else begin
                    nxt  = S_ERROR;
                    nerr = ERR_INDEX;
                end
            end
            S_CMD55B: begin
                if (r_idx == 6'd55) begin
                    nxt = S_ACMD6;
                end else begin
                    nxt  = S_ERROR;
                    nerr = ERR_INDEX;
                end
            end
            S_ACMD6: begin
                if (r_idx == 6'd6) begin
                    nxt = S_DONE;
                end else begin
                    nxt  = S_ERROR;
                    nerr = ERR_INDEX;
                end
            end
            default: nxt = state;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= S_IDLE;
            wait_gap   <= 1'b0;
            retry_cnt  <= '0;
            gap_cnt    <= '0;
            ocmd_start <= 1'b0;
            ocmd_index <= 6'd0;
            ocmd_arg   <= 32'd0;
            orca       <= 16'd0;
            obusy      <= 1'b0;
            odone      <= 1'b0;
            oerror     <= 1'b0;
            oerr_code  <= 3'd0;
`ifdef SD_INIT_WIDE_BUS_EN
            obus4      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (istart) begin
                        state      <= S_CMD0;
                        wait_gap   <= 1'b0;
                        retry_cnt  <= '0;
                        gap_cnt    <= '0;
                        ocmd_start <= 1'b1;
                        ocmd_index <= 6'd0;
                        ocmd_arg   <= 32'd0;
                        orca       <= 16'd0;
                        obusy      <= 1'b1;
                        odone      <= 1'b0;
                        oerror     <= 1'b0;
                        oerr_code  <= 3'd0;
`ifdef SD_INIT_WIDE_BUS_EN
                        obus4      <= 1'b0;
`endif
                    end
                end
                default: begin
                    if (wait_gap) begin
                        if (gap_end) begin
                            wait_gap   <= 1'b0;
                            gap_cnt    <= '0;
                            ocmd_start <= 1'b1;
                            ocmd_index <= idx_of(state);
                            ocmd_arg   <= arg_of(state, orca);
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end else if (ocmd_start && icmd_done) begin
                        ocmd_start <= 1'b0;
                        state      <= nxt;
                        if (state == S_ACMD41 && !r_arg[31]) begin
                            retry_cnt <= retry_nx;
                        end
                        if (state == S_CMD3 && r_idx == 6'd3) begin
                            orca <= r_arg[31:16];
                        end
                        if (nxt == S_DONE) begin
                            obusy <= 1'b0;
                            odone <= 1'b1;
`ifdef SD_INIT_WIDE_BUS_EN
                            obus4 <= 1'b1;
`endif
                        end else if (nxt == S_ERROR) begin
                            obusy     <= 1'b0;
                            oerror    <= 1'b1;
                            oerr_code <= nerr;
                        end else begin
                            wait_gap <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifndef SD_INIT_WIDE_BUS_EN
    assign obus4 = 1'b0;
`endif

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Directed bench for sd_init_ctrl with a card model and command scoreboard.
// Honours SD_INIT_WIDE_BUS_EN for the expected tail of the sequence.
module tb_sd_init_ctrl;

    localparam int RETRIES = 5;
    localparam int GAP     = 8;
`ifdef SD_INIT_WIDE_BUS_EN
    localparam int  TAIL_N  = 5;
    localparam logic EXP_B4 = 1'b1;
`else
    localparam int  TAIL_N  = 3;
    localparam logic EXP_B4 = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         irst = 1'b1;
    logic         istart = 1'b0;
    logic         ocmd_start;
    logic [5:0]   ocmd_index;
    logic [31:0]  ocmd_arg;
    logic [119:0] icmd_resp = '0;
    logic         icmd_done = 1'b0;
    logic [15:0]  orca;
    logic         obusy;
    logic         odone;
    logic         oerror;
    logic [2:0]   oerr_code;
    logic         obus4;

    always #5 clk = ~clk;

    sd_init_ctrl #(
        .ACMD41_RETRIES(RETRIES),
        .ACMD41_ARG(32'h40FF8000),
        .GAP_CYCLES(GAP)
    ) dut (
        .iclk(clk),
        .irst(irst),
        .istart(istart),
        .ocmd_start(ocmd_start),
        .ocmd_index(ocmd_index),
        .ocmd_arg(ocmd_arg),
        .icmd_resp(icmd_resp),
        .icmd_done(icmd_done),
        .orca(orca),
        .obusy(obusy),
        .odone(odone),
        .oerror(oerror),
        .oerr_code(oerr_code),
        .obus4(obus4)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [37:0] exp_q[$];
    logic [31:0] cmd8_arg = 32'h1AA;
    logic [5:0]  cmd55_idx = 6'd55;
    logic [31:0] cmd3_arg = 32'hAAAA0500;
    int          busy_left = 0;
    bit          gap_valid = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] i, input logic [31:0] a);
        exp_q.push_back({i, a});
    endtask

    task automatic push_tail();
        push(6'd2, 32'h0);
        push(6'd3, 32'h0);
        push(6'd7, 32'hAAAA0000);
`ifdef SD_INIT_WIDE_BUS_EN
        push(6'd55, 32'hAAAA0000);
        push(6'd6, 32'h2);
`endif
    endtask

    // Card model: response for the command currently presented
    task automatic make_resp(input logic [5:0] idx, output logic [119:0] r);
        r = '0;
        case (idx)
            6'd8: begin
                r[37:32] = 6'd8;
                r[31:0]  = cmd8_arg;
            end
            6'd55: begin
                r[37:32] = cmd55_idx;
                r[31:0]  = 32'h120;
            end
            6'd41: begin
                r[37:32] = 6'h3F;
                r[31:0]  = (busy_left != 0) ? 32'h00FF8000 : 32'h80FF8000;
                if (busy_left > 0) busy_left--;
            end
            6'd2: r[95:0] = {$urandom, $urandom, $urandom};
            6'd3: begin
                r[37:32] = 6'd3;
                r[31:0]  = cmd3_arg;
            end
            6'd7: begin
                r[37:32] = 6'd7;
                r[31:0]  = 32'h900;
            end
            6'd6: begin
                r[37:32] = 6'd6;
                r[31:0]  = 32'h920;
            end
            default: r = '0;
        endcase
    endtask

    task automatic wait_start();
        int n = 0;
        logic [37:0] e;
        while (ocmd_start !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("start_seen", 64'(ocmd_start), 64'd1);
        if (gap_valid) check("gap", 64'(n), 64'(GAP));
        if (exp_q.size() == 0) begin
            check("unexpected_cmd", 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("cmd", 64'({ocmd_index, ocmd_arg}), 64'(e));
        end
    endtask

    task automatic finish_cmd();
        logic [119:0] r;
        repeat (2) @(negedge clk);
        check("start_hold", 64'(ocmd_start), 64'd1);
        make_resp(ocmd_index, r);
        icmd_resp = r;
        icmd_done = 1'b1;
        @(negedge clk);
        icmd_done = 1'b0;
        check("start_drop", 64'(ocmd_start), 64'd0);
        gap_valid = 1;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) begin
            wait_start();
            finish_cmd();
        end
    endtask

    task automatic go();
        gap_valid = 0;
        istart = 1'b1;
        @(negedge clk);
        istart = 1'b0;
    endtask

    task automatic no_more_start();
        logic seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (ocmd_start) seen = 1'b1;
        end
        check("no_start", 64'(seen), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        irst = 1'b0;
        check("rst_start", 64'(ocmd_start), 64'd0);
        check("rst_index", 64'(ocmd_index), 64'd0);
        check("rst_arg", 64'(ocmd_arg), 64'd0);
        check("rst_rca", 64'(orca), 64'd0);
        check("rst_busy", 64'(obusy), 64'd0);
        check("rst_done", 64'(odone), 64'd0);
        check("rst_error", 64'(oerror), 64'd0);
        check("rst_code", 64'(oerr_code), 64'd0);
        check("rst_bus4", 64'(obus4), 64'd0);

        // Nominal sequence
        push(6'd0, 32'h0);
        push(6'd8, 32'h1AA);
        push(6'd55, 32'h0);
        push(6'd41, 32'h40FF8000);
        push_tail();
        go();
        check("nom_busy", 64'(obusy), 64'd1);
        run(4 + TAIL_N);
        check("nom_done", 64'(odone), 64'd1);
        check("nom_busy_end", 64'(obusy), 64'd0);
        check("nom_rca", 64'(orca), 64'hAAAA);
        check("nom_bus4", 64'(obus4), 64'(EXP_B4));
        check("nom_error", 64'(oerror), 64'd0);
        no_more_start();

        // ACMD41 busy three times, then ready
        busy_left = 3;
        push(6'd0, 32'h0);
        push(6'd8, 32'h1AA);
        for (int i = 0; i < 4; i++) begin
            push(6'd55, 32'h0);
            push(6'd41, 32'h40FF8000);
        end
        push_tail();
        go();
        check("busy_rca_clr", 64'(orca), 64'd0);
        check("busy_done_clr", 64'(odone), 64'd0);
        run(2 + 8 + TAIL_N);
        check("busy_done", 64'(odone), 64'd1);
        check("busy_rca", 64'(orca), 64'hAAAA);

        // Bad CMD8 echo, then restart from ERROR
        cmd8_arg = 32'h1AB;
        push(6'd0, 32'h0);
        push(6'd8, 32'h1AA);
        go();
        check("c8_rca_clr", 64'(orca), 64'd0);
        run(2);
        check("c8_error", 64'(oerror), 64'd1);
        check("c8_code", 64'(oerr_code), 64'd1);
        check("c8_busy", 64'(obusy), 64'd0);
        no_more_start();
        cmd8_arg = 32'h1AA;
        push(6'd0, 32'h0);
        push(6'd8, 32'h1AA);
        push(6'd55, 32'h0);
        push(6'd41, 32'h40FF8000);
        push_tail();
        go();
        check("re_error_clr", 64'(oerror), 64'd0);
        check("re_code_clr", 64'(oerr_code), 64'd0);
        check("re_busy", 64'(obusy), 64'd1);
        run(4 + TAIL_N);
        check("re_done", 64'(odone), 64'd1);

        // ACMD41 never ready
        busy_left = -1;
        push(6'd0, 32'h0);
        push(6'd8, 32'h1AA);
        for (int i = 0; i < RETRIES; i++) begin
            push(6'd55, 32'h0);
            push(6'd41, 32'h40FF8000);
        end
        go();
        run(2 + 2 * RETRIES);
        check("tmo_error", 64'(oerror), 64'd1);
        check("tmo_code", 64'(oerr_code), 64'd2);
        check("tmo_start", 64'(ocmd_start), 64'd0);
        check("tmo_done", 64'(odone), 64'd0);
        no_more_start();

        // CMD55 answered with a wrong index
        busy_left = 0;
        cmd55_idx = 6'h11;
        push(6'd0, 32'h0);
        push(6'd8, 32'h1AA);
        push(6'd55, 32'h0);
        go();
        run(3);
        check("idx_error", 64'(oerror), 64'd1);
        check("idx_code", 64'(oerr_code), 64'd3);
        no_more_start();

        // Reset while CMD2 start is high
        cmd55_idx = 6'd55;
        push(6'd0, 32'h0);
        push(6'd8, 32'h1AA);
        push(6'd55, 32'h0);
        push(6'd41, 32'h40FF8000);
        push(6'd2, 32'h0);
        go();
        run(4);
        wait_start();
        irst = 1'b1;
        @(negedge clk);
        irst = 1'b0;
        gap_valid = 0;
        check("mid_rst_start", 64'(ocmd_start), 64'd0);
        check("mid_rst_busy", 64'(obusy), 64'd0);
        check("mid_rst_error", 64'(oerror), 64'd0);
        no_more_start();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
